// File: rtl/sprite_sequencer.sv
// Sprite command sequencer: queues per-frame draw commands and, on frame_start,
// feeds them one at a time to the sprite renderer with reset/enable sequencing.
module sprite_sequencer #(
    parameter int CORDW      = 10,
    parameter int SPR_WIDTH  = 32,
    parameter int SPR_HEIGHT = 32,
    parameter int ID_W       = 4,
    parameter int DEPTH      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CORDW-1:0] cmd_x,
    input  logic [CORDW-1:0] cmd_y,
    input  logic [2:0]       cmd_scale,
    input  logic [ID_W-1:0]  cmd_id,
    input  logic             frame_start,
    output logic             rnd_rst,
    output logic             rnd_enable,
    output logic [CORDW-1:0] rnd_sx,
    output logic [CORDW-1:0] rnd_sy,
    output logic [2:0]       rnd_scale,
    output logic [ID_W-1:0]  rnd_id,
    output logic             busy,
    output logic             frame_done,
    output logic             overrun
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(SPR_WIDTH*SPR_HEIGHT*64) + 1;

    typedef struct packed {
        logic [CORDW-1:0] x;
        logic [CORDW-1:0] y;
        logic [2:0]       scale;
        logic [ID_W-1:0]  id;
    } cmd_t;

    typedef enum logic [2:0] {IDLE, LOAD, ARM, RUN, DONE} state_t;

    state_t          state_q, state_d;
    cmd_t            mem_q [DEPTH];
    logic [AW:0]     wr_ptr_q, rd_ptr_q, count;
    logic            empty, full, push, pop;
    cmd_t            head;
    logic [3:0]      sp1;
    logic [6:0]      sq;
    logic [PW-1:0]   pix_cnt_q, pix_load;
    logic            rnd_rst_d, rnd_enable_d, frame_done_d, overrun_d;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count     = wr_ptr_q - rd_ptr_q;
    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == LOAD) && !empty;
    assign head      = mem_q[rd_ptr_q[AW-1:0]];
    assign busy      = (state_q != IDLE);

    // Pixel count minus one, so RUN lasts exactly the full sprite area.
    assign sp1      = {1'b0, head.scale} + 4'd1;
    assign sq       = 7'(sp1) * 7'(sp1);
    assign pix_load = PW'(SPR_WIDTH*SPR_HEIGHT) * PW'(sq) - PW'(1);

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= '{x: cmd_x, y: cmd_y, scale: cmd_scale, id: cmd_id};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pix_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                pix_cnt_q <= pix_load;
            end else if (state_q == RUN) begin
                pix_cnt_q <= pix_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_start) state_d = empty ? DONE : LOAD;
            LOAD:    state_d = ARM;
            ARM:     state_d = RUN;
            RUN:     if (pix_cnt_q == '0) state_d = empty ? DONE : LOAD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs are decoded from the next state so they align with it.
    always_comb begin
        rnd_rst_d    = (state_d == ARM);
        rnd_enable_d = (state_d == RUN);
        frame_done_d = (state_d == DONE);
        overrun_d    = overrun;
        if (frame_start) overrun_d = (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd_rst    <= 1'b1;
            rnd_enable <= 1'b0;
            rnd_sx     <= '0;
            rnd_sy     <= '0;
            rnd_scale  <= '0;
            rnd_id     <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rnd_rst    <= rnd_rst_d;
            rnd_enable <= rnd_enable_d;
            frame_done <= frame_done_d;
            overrun    <= overrun_d;
            if (pop) begin
                rnd_sx    <= head.x;
                rnd_sy    <= head.y;
                rnd_scale <= head.scale;
                rnd_id    <= head.id;
            end
        end
    end
endmodule

// File: tb/tb_sprite_sequencer.sv
// Scoreboard bench for sprite_sequencer: accepted commands are queued as expected
// sprites and checked against each ARM/RUN sequence the DUT produces.
module tb_sprite_sequencer;
    localparam int CORDW = 10, SPR_WIDTH = 32, SPR_HEIGHT = 32, ID_W = 4, DEPTH = 8;

    logic             clk = 1'b0, rst_n = 1'b0;
    logic             cmd_valid = 1'b0, cmd_ready, frame_start = 1'b0;
    logic [CORDW-1:0] cmd_x = '0, cmd_y = '0;
    logic [2:0]       cmd_scale = '0;
    logic [ID_W-1:0]  cmd_id = '0;
    logic             rnd_rst, rnd_enable, busy, frame_done, overrun;
    logic [CORDW-1:0] rnd_sx, rnd_sy;
    logic [2:0]       rnd_scale;
    logic [ID_W-1:0]  rnd_id;

    sprite_sequencer #(.CORDW(CORDW), .SPR_WIDTH(SPR_WIDTH), .SPR_HEIGHT(SPR_HEIGHT),
                       .ID_W(ID_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_scale(cmd_scale), .cmd_id(cmd_id),
        .frame_start(frame_start), .rnd_rst(rnd_rst), .rnd_enable(rnd_enable),
        .rnd_sx(rnd_sx), .rnd_sy(rnd_sy), .rnd_scale(rnd_scale), .rnd_id(rnd_id),
        .busy(busy), .frame_done(frame_done), .overrun(overrun));

    always #5 clk = ~clk;

    typedef struct { int x; int y; int s; int id; } exp_t;
    exp_t exp_q[$];
    int   n_chk = 0, n_err = 0, fd_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int npix(input int s);
        return SPR_WIDTH * SPR_HEIGHT * (s + 1) * (s + 1);
    endfunction

    // Monitor state
    int   run_len = 0, low_cnt = 0;
    bit   in_run = 0, prev_rst = 1, arm_prev = 0, had_run = 0, prev_fd = 0, was_arm;
    exp_t cur = '{0, 0, 0, 0};

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            run_len = 0; in_run = 0; prev_rst = 1; arm_prev = 0;
            had_run = 0; low_cnt = 0; prev_fd = 0;
        end else begin
            was_arm  = arm_prev;
            arm_prev = 0;
            if (was_arm) begin
                chk("arm_one_cycle", rnd_rst, 0);
                chk("en_after_arm", rnd_enable, 1);
            end
            if (rnd_rst && !prev_rst) begin
                chk("arm_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    chk("rnd_sx", rnd_sx, cur.x);
                    chk("rnd_sy", rnd_sy, cur.y);
                    chk("rnd_scale", rnd_scale, cur.s);
                    chk("rnd_id", rnd_id, cur.id);
                end
                chk("arm_no_enable", rnd_enable, 0);
                arm_prev = 1;
            end
            if (rnd_enable) begin
                if (!in_run) begin
                    chk("en_needs_arm", was_arm, 1);
                    if (had_run) chk("dead_gap", low_cnt, 2);
                    in_run  = 1;
                    run_len = 0;
                end
                run_len++;
            end else begin
                if (in_run) begin
                    chk("run_len", run_len, npix(cur.s));
                    chk("fd_after_last", frame_done, exp_q.size() == 0);
                    in_run  = 0;
                    had_run = 1;
                    low_cnt = 0;
                end
                if (had_run) low_cnt++;
            end
            if (frame_done) begin
                fd_cnt++;
                chk("sb_drained", exp_q.size(), 0);
                had_run = 0;
            end
            if (prev_fd) begin
                chk("fd_one_cycle", frame_done, 0);
                chk("busy_fall", busy, 0);
            end
            prev_fd  = frame_done;
            prev_rst = rnd_rst;
        end
    end

    task automatic push(input int x, input int y, input int s, input int id, output bit acc);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_x = CORDW'(x); cmd_y = CORDW'(y); cmd_scale = 3'(s); cmd_id = ID_W'(id);
        acc = cmd_ready;
        if (acc) exp_q.push_back('{x, y, s, id});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic start_frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        bit seen = 0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            seen = frame_done;
        end
        if (!seen) chk(tag, 0, 1);
        @(negedge clk);
    endtask

    int fd0;
    bit acc;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rnd_rst", rnd_rst, 1);
        chk("rst_enable", rnd_enable, 0);
        chk("rst_sx", rnd_sx, 0);
        chk("rst_sy", rnd_sy, 0);
        chk("rst_id", rnd_id, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cmd_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rnd_rst_released", rnd_rst, 0);

        // Single sprite
        fd0 = fd_cnt;
        push(100, 50, 0, 3, acc);
        chk("t1_acc", acc, 1);
        start_frame();
        @(negedge clk);
        chk("t1_load_busy", busy, 1);
        chk("t1_load_no_rst", rnd_rst, 0);
        wait_done("t1_timeout", 5000);
        chk("t1_fd_count", fd_cnt - fd0, 1);

        // Empty frame
        fd0 = fd_cnt;
        start_frame();
        @(negedge clk);
        chk("t4_fd_next", frame_done, 1);
        chk("t4_no_rst", rnd_rst, 0);
        chk("t4_no_en", rnd_enable, 0);
        repeat (3) @(negedge clk);
        chk("t4_fd_count", fd_cnt - fd0, 1);

        // Two scaled sprites back to back
        fd0 = fd_cnt;
        push(7, 9, 1, 5, acc);
        push(1023, 0, 2, 15, acc);
        start_frame();
        wait_done("t2_timeout", 20000);
        chk("t2_fd_count", fd_cnt - fd0, 1);

        // Fill FIFO, reject 9th, ready returns on first pop
        for (int i = 0; i < DEPTH; i++) begin
            push(10 * i, 3 * i + 1, 0, i, acc);
            chk("t3_acc", acc, 1);
        end
        @(negedge clk);
        chk("t3_full_ready", cmd_ready, 0);
        push(999, 999, 0, 9, acc);
        chk("t3_ninth_rej", acc, 0);
        fd0 = fd_cnt;
        start_frame();
        @(negedge clk);
        chk("t3_ready_in_load", cmd_ready, 0);
        @(negedge clk);
        chk("t3_ready_after_pop", cmd_ready, 1);
        wait_done("t3_timeout", 20000);
        chk("t3_fd_count", fd_cnt - fd0, 1);

        // Overrun: frame_start + push during RUN
        fd0 = fd_cnt;
        push(20, 30, 0, 1, acc);
        start_frame();
        for (int i = 0; i < 200 && !rnd_enable; i++) @(negedge clk);
        repeat (100) @(negedge clk);
        chk("t5_in_run", rnd_enable, 1);
        cmd_valid = 1'b1; cmd_x = 10'd555; cmd_y = 10'd444; cmd_scale = 3'd0; cmd_id = 4'd12;
        frame_start = 1'b1;
        acc = cmd_ready;
        if (acc) exp_q.push_back('{555, 444, 0, 12});
        @(posedge clk); #1;
        cmd_valid = 1'b0; frame_start = 1'b0;
        @(negedge clk);
        chk("t5_overrun_set", overrun, 1);
        chk("t5_still_run", rnd_enable, 1);
        wait_done("t5_timeout", 5000);
        chk("t5_fd_count", fd_cnt - fd0, 1);
        chk("t5_overrun_sticky", overrun, 1);
        fd0 = fd_cnt;
        start_frame();
        @(negedge clk);
        chk("t5_empty_fd", frame_done, 1);
        chk("t5_overrun_clr", overrun, 0);

        // Reset mid-RUN with commands queued
        push(1, 2, 0, 4, acc);
        push(3, 4, 1, 5, acc);
        push(5, 6, 0, 6, acc);
        start_frame();
        for (int i = 0; i < 200 && !rnd_enable; i++) @(negedge clk);
        repeat (500) @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("t6_en_low", rnd_enable, 0);
        chk("t6_rst_high", rnd_rst, 1);
        chk("t6_sx_rst", rnd_sx, 0);
        chk("t6_busy", busy, 0);
        chk("t6_ready", cmd_ready, 1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        fd0 = fd_cnt;
        start_frame();
        @(negedge clk);
        chk("t6_fd_next", frame_done, 1);
        chk("t6_no_rst", rnd_rst, 0);
        chk("t6_no_en", rnd_enable, 0);
        repeat (5) @(negedge clk);
        chk("t6_fd_count", fd_cnt - fd0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/sprite_sequencer.md
# sprite_sequencer

Upstream stage of the sprite renderer. Buffers per-frame sprite draw commands (position, scale, sprite id) in a small FIFO and, once a frame is started, issues them one at a time to the renderer. For each sprite it drives the renderer's reset, position, scale and enable, and holds enable for exactly the renderer's pixel count. It pulses `frame_done` when the queue has drained.

## Interface
- `CORDW`, 10: screen coordinate width.
- `SPR_WIDTH`, 32: sprite width in source pixels.
- `SPR_HEIGHT`, 32: sprite height in source pixels.
- `ID_W`, 4: sprite id width (selects sprite ROM image).
- `DEPTH`, 8: command FIFO depth; must be a power of 2.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: FIFO not full; a command is accepted when `cmd_valid && cmd_ready`.
- `cmd_x`, `cmd_y` in CORDW: sprite top-left screen position.
- `cmd_scale` in 3: scale s; output size is `SPR_WIDTH*(s+1)` by `SPR_HEIGHT*(s+1)`.
- `cmd_id` in ID_W: sprite image id.
- `frame_start` in 1: single-cycle pulse; drain the queue.
- `rnd_rst` out 1: synchronous reset to the renderer.
- `rnd_enable` out 1: renderer enable.
- `rnd_sx`, `rnd_sy` out CORDW: renderer position.
- `rnd_scale` out 3: renderer scale.
- `rnd_id` out ID_W: renderer sprite id.
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: single-cycle pulse when draining completes.
- `overrun` out 1: sticky; set when `frame_start` arrives while busy.

## Operation
- FIFO: DEPTH entries of {x, y, scale, id}.
  - Push and pop in the same cycle leave occupancy unchanged.
  - A push while full is impossible because `cmd_ready` is low.
  - A pop happens only in LOAD, and only when the FIFO is non-empty.
- FSM states: IDLE, LOAD, ARM, RUN, DONE.
  - IDLE: on `frame_start`, go to LOAD if the FIFO is non-empty, else go to DONE.
  - LOAD: pop the head entry into the `rnd_*` output registers; load `pix_cnt = SPR_WIDTH*SPR_HEIGHT*(scale+1)^2 - 1`; go to ARM.
  - ARM: `rnd_rst=1` for one cycle; go to RUN.
  - RUN: `rnd_enable=1`; `pix_cnt` decrements each cycle. On the cycle `pix_cnt==0`, go to LOAD if the FIFO is non-empty, else go to DONE.
  - DONE: `frame_done=1` for one cycle; go to IDLE.
- Commands pushed during a drain are drawn in the same drain, because the non-empty check is made at RUN exit.
- `pix_cnt` width is `clog2(SPR_WIDTH*SPR_HEIGHT*64)+1`, i.e. 17 bits at default parameters. The multiply uses only constants and `(scale+1)^2`, which is at most 64.
- `frame_start` outside IDLE is otherwise ignored: no restart, no effect on the drain. It sets `overrun`. `overrun` clears on the next `frame_start` accepted in IDLE.
- `rnd_sx`, `rnd_sy`, `rnd_scale`, `rnd_id` hold their value from LOAD until the next LOAD.

## Timing
- All outputs are registered except `cmd_ready` (which is `!full`) and `busy` (which is `state != IDLE`).
- Reset values:
  - `rnd_rst=1`, so the renderer is held in reset.
  - `rnd_enable=0`, `rnd_sx=0`, `rnd_sy=0`, `rnd_scale=0`, `rnd_id=0`.
  - `frame_done=0`, `overrun=0`.
  - FIFO empty, state IDLE, `cmd_ready=1`.
- Outside ARM, `rnd_rst=0` once out of reset.
- `frame_start` sampled at cycle t, non-empty FIFO:
  - t+1: LOAD.
  - t+2: ARM, `rnd_rst` high, new `rnd_*` values visible.
  - t+3 to t+2+N: `rnd_enable` high for exactly N cycles, where `N = SPR_WIDTH*SPR_HEIGHT*(s+1)^2`.
- Between consecutive sprites there are 2 dead cycles (LOAD, ARM) with `rnd_enable=0`.
- After the last RUN cycle, `frame_done` is high in the next cycle.
- `frame_start` sampled at cycle t with an empty FIFO: `frame_done` is high at t+1.
- Asserting `rst_n` low mid-operation immediately:
  - forces every output to its reset value,
  - empties the FIFO,
  - returns to IDLE.
  
  No `frame_done` is issued.

## Test plan
- Reset, then push one command {x=100, y=50, s=0, id=3}, then pulse `frame_start` → `rnd_rst` high for 1 cycle with `rnd_sx=100`, `rnd_sy=50`, `rnd_id=3`; then `rnd_enable` high for exactly 1024 cycles; then `frame_done` pulses once; `busy` falls.
- Push {s=1} and {s=2}, then start a frame → enable runs of 4096 and 9216 cycles, separated by exactly 2 low cycles; one `frame_done`.
- Push 8 commands → `cmd_ready` is 0 after the 8th; a 9th `cmd_valid` is not accepted. Start the frame → during the first LOAD pop, `cmd_ready` returns to 1.
- `frame_start` with an empty FIFO → `frame_done` the next cycle; no `rnd_rst`, no `rnd_enable`.
- During RUN, pulse `frame_start` and push a new command in the same cycle → `overrun=1`; the pushed sprite is drawn in the same drain; one `frame_done`. The next `frame_start` clears `overrun`.
- Drop `rst_n` midway through a RUN with 3 commands queued → `rnd_enable=0` and `rnd_rst=1` immediately; the FIFO is empty after release. A later `frame_start` yields `frame_done` at t+1 only.
